// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared game constants: screen geometry, ship size, colour constants, the
// player-missile state encoding and a launch-position helper.
// No ports (package).
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int unsigned SCREEN_W = 800;
  localparam int unsigned SCREEN_H = 600;
  localparam int unsigned SHIP_W   = 64;

  localparam logic [11:0] COLOR_BLACK   = 12'h000;
  localparam logic [11:0] COLOR_MISSILE = 12'hFF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } missile_state_t;

  // Left edge of an object of width inner_w centred on an object of width
  // outer_w whose left edge is 'left'. Unsigned 11-bit arithmetic.
  function automatic logic [10:0] centre_x(input logic [10:0] left,
                                           input int unsigned outer_w,
                                           input int unsigned inner_w);
    return left + 11'(outer_w / 2 - inner_w / 2);
  endfunction

endpackage

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if
// One stage of the VGA timing/rgb pipeline: counters, sync/blank strobes and
// the pixel colour.
//   master : drives the bundle (pipeline stage output)
//   slave  : receives the bundle (pipeline stage input)
// ---------------------------------------------------------------------------
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/missile_draw.sv
// ---------------------------------------------------------------------------
// missile_draw
// One-cycle VGA pipeline stage that overlays a solid W x H rectangle of
// colour COLOR at (x, y) when 'on' is set and the beam is in the active area.
// Ports:
//   clk   in   pixel clock
//   rst   in   asynchronous, active-low reset (all outputs to 0)
//   vin   in   upstream VGA bundle
//   vout  out  VGA bundle delayed by one cycle, rgb overlaid
//   x, y  in   rectangle top-left corner
//   on    in   rectangle visible
// ---------------------------------------------------------------------------
module missile_draw
  import game_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned H     = 12,
  parameter logic [11:0] COLOR = COLOR_MISSILE
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.slave        vin,
  vga_if.master       vout,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        on
);

  localparam logic [11:0] W12 = 12'(W);
  localparam logic [11:0] H12 = 12'(H);

  logic in_x_s;
  logic in_y_s;
  logic paint_s;

  // Rectangle hit test; compare in 12 bits so x+W / y+H cannot wrap.
  always_comb begin
    in_x_s  = ({1'b0, vin.hcount} >= {1'b0, x}) &&
              ({1'b0, vin.hcount} <  ({1'b0, x} + W12));
    in_y_s  = ({1'b0, vin.vcount} >= {1'b0, y}) &&
              ({1'b0, vin.vcount} <  ({1'b0, y} + H12));
    paint_s = on && !vin.hblnk && !vin.vblnk && in_x_s && in_y_s;
  end

  // Pipeline register: timing delayed one cycle, rgb overlaid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vout.vcount <= 11'd0;
      vout.hcount <= 11'd0;
      vout.vsync  <= 1'b0;
      vout.vblnk  <= 1'b0;
      vout.hsync  <= 1'b0;
      vout.hblnk  <= 1'b0;
      vout.rgb    <= 12'h000;
    end else begin
      vout.vcount <= vin.vcount;
      vout.hcount <= vin.hcount;
      vout.vsync  <= vin.vsync;
      vout.vblnk  <= vin.vblnk;
      vout.hsync  <= vin.hsync;
      vout.hblnk  <= vin.hblnk;
      vout.rgb    <= paint_s ? COLOR : vin.rgb;
    end
  end

endmodule

// File: rtl/player_missile.sv
// ---------------------------------------------------------------------------
// player_missile
// Player missile source. A fire press launches one missile centred above the
// ship; it climbs SPEED px per frame (updates only on the vblnk rising edge),
// ends on an enemy hit or at the screen top, then waits COOLDOWN frames
// before re-arming. Also draws the missile as one VGA pipeline stage.
// Ports:
//   pclk          in   pixel clock
//   rst           in   asynchronous, active-low reset
//   fire          in   fire key level (pclk domain)
//   xpos_ship     in   ship top-left x
//   ypos_ship     in   ship top-left y
//   hit           in   1-cycle enemy collision pulse
//   vin           in   upstream VGA bundle
//   vout          out  VGA bundle delayed 1 cycle, missile overlaid
//   xpos_missile  out  missile top-left x (valid while on_missle)
//   ypos_missile  out  missile top-left y (valid while on_missle)
//   on_missle     out  missile in flight
// ---------------------------------------------------------------------------
module player_missile #(
  parameter int unsigned MISSILE_W = 4,
  parameter int unsigned MISSILE_H = 12,
  parameter int unsigned SHIP_W    = game_pkg::SHIP_W,
  parameter int unsigned SPEED     = 6,
  parameter int unsigned Y_TOP     = 0,
  parameter int unsigned COOLDOWN  = 8,
  parameter logic [11:0] COLOR     = game_pkg::COLOR_MISSILE
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        fire,
  input  logic [10:0] xpos_ship,
  input  logic [10:0] ypos_ship,
  input  logic        hit,
  vga_if.slave        vin,
  vga_if.master       vout,
  output logic [10:0] xpos_missile,
  output logic [10:0] ypos_missile,
  output logic        on_missle
);

  localparam logic [10:0] SPEED11   = 11'(SPEED);
  localparam logic [10:0] HEIGHT11  = 11'(MISSILE_H);
  // Below this y another step would pass the top limit (or wrap).
  localparam logic [10:0] Y_LIMIT   = 11'(Y_TOP + SPEED);
  localparam int          CNT_W     = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN - 1);

  game_pkg::missile_state_t state_r, state_n;
  logic [10:0]      x_r, x_n;
  logic [10:0]      y_r, y_n;
  logic             on_r, on_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             fire_d_r;
  logic             vblnk_d_r;
  logic             fire_rise_s;
  logic             frame_tick_s;

  // Edge detectors for the fire key and the start of vertical blanking.
  always_comb begin
    fire_rise_s  = fire & ~fire_d_r;
    frame_tick_s = vin.vblnk & ~vblnk_d_r;
  end

  // Delay registers feeding the edge detectors.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      fire_d_r  <= 1'b0;
      vblnk_d_r <= 1'b0;
    end else begin
      fire_d_r  <= fire;
      vblnk_d_r <= vin.vblnk;
    end
  end

  // Missile FSM next-state and datapath.
  always_comb begin
    state_n = state_r;
    x_n     = x_r;
    y_n     = y_r;
    on_n    = on_r;
    cnt_n   = cnt_r;
    case (state_r)
      game_pkg::IDLE: begin
        if (fire_rise_s) begin
          x_n     = game_pkg::centre_x(xpos_ship, SHIP_W, MISSILE_W);
          y_n     = ypos_ship - HEIGHT11;
          on_n    = 1'b1;
          state_n = game_pkg::FLIGHT;
        end else begin
          state_n = game_pkg::IDLE;
        end
      end
      game_pkg::FLIGHT: begin
        // A hit wins over a coincident frame tick; fire is ignored in flight.
        if (hit) begin
          on_n    = 1'b0;
          cnt_n   = {CNT_W{1'b0}};
          state_n = game_pkg::COOLDOWN;
        end else if (frame_tick_s) begin
          // Limit check precedes the subtraction so y never wraps.
          if (y_r < Y_LIMIT) begin
            on_n    = 1'b0;
            cnt_n   = {CNT_W{1'b0}};
            state_n = game_pkg::COOLDOWN;
          end else begin
            y_n     = y_r - SPEED11;
          end
        end else begin
          state_n = game_pkg::FLIGHT;
        end
      end
      game_pkg::COOLDOWN: begin
        if (frame_tick_s) begin
          if (cnt_r == CNT_LAST) begin
            cnt_n   = {CNT_W{1'b0}};
            state_n = game_pkg::IDLE;
          end else begin
            cnt_n   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_n = game_pkg::COOLDOWN;
        end
      end
      default: begin
        on_n    = 1'b0;
        cnt_n   = {CNT_W{1'b0}};
        state_n = game_pkg::IDLE;
      end
    endcase
  end

  // Missile FSM state and datapath registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_r <= game_pkg::IDLE;
      x_r     <= 11'd0;
      y_r     <= 11'd0;
      on_r    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n;
      x_r     <= x_n;
      y_r     <= y_n;
      on_r    <= on_n;
      cnt_r   <= cnt_n;
    end
  end

  assign xpos_missile = x_r;
  assign ypos_missile = y_r;
  assign on_missle    = on_r;

  missile_draw #(
    .W     (MISSILE_W),
    .H     (MISSILE_H),
    .COLOR (COLOR)
  ) u_draw (
    .clk  (pclk),
    .rst  (rst),
    .vin  (vin),
    .vout (vout),
    .x    (x_r),
    .y    (y_r),
    .on   (on_r)
  );

endmodule

// File: tb/tb_player_missile.sv
// ---------------------------------------------------------------------------
// tb_player_missile
// Directed bench for player_missile with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_player_missile;
  import game_pkg::*;

  logic        pclk;
  logic        rst;
  logic        fire;
  logic [10:0] xpos_ship;
  logic [10:0] ypos_ship;
  logic        hit;
  logic [10:0] xpos_missile;
  logic [10:0] ypos_missile;
  logic        on_missle;

  vga_if vin ();
  vga_if vout ();

  int n_pass;
  int n_total;

  player_missile dut (
    .pclk         (pclk),
    .rst          (rst),
    .fire         (fire),
    .xpos_ship    (xpos_ship),
    .ypos_ship    (ypos_ship),
    .hit          (hit),
    .vin          (vin),
    .vout         (vout),
    .xpos_missile (xpos_missile),
    .ypos_missile (ypos_missile),
    .on_missle    (on_missle)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Rising edge of vblnk: the tick is consumed at the next clock edge.
  task automatic tick_edge();
    vin.vblnk = 1'b1;
    step();
  endtask

  task automatic frame_tail();
    repeat (3) step();
    vin.vblnk = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_frame();
    tick_edge();
    frame_tail();
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
  endtask

  initial begin
    logic [10:0] prev_h;
    logic [11:0] exp_rgb;
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    fire       = 1'b0;
    hit        = 1'b0;
    xpos_ship  = 11'd368;
    ypos_ship  = 11'd540;
    vin.vcount = 11'd5;
    vin.hcount = 11'd5;
    vin.vsync  = 1'b1;
    vin.vblnk  = 1'b0;
    vin.hsync  = 1'b1;
    vin.hblnk  = 1'b1;
    vin.rgb    = 12'h0F0;

    // Reset state
    repeat (3) step();
    check("rst_on",   32'(on_missle),    32'd0);
    check("rst_x",    32'(xpos_missile), 32'd0);
    check("rst_y",    32'(ypos_missile), 32'd0);
    check("rst_rgb",  32'(vout.rgb),     32'h0);
    check("rst_hcnt", 32'(vout.hcount),  32'd0);
    check("rst_st",   32'(dut.state_r),  32'(IDLE));
    rst = 1'b1;
    step();

    // 1: launch from ship at (368,540)
    fire = 1'b1;
    step();
    check("t1_on", 32'(on_missle),    32'd1);
    check("t1_x",  32'(xpos_missile), 32'd398);
    check("t1_y",  32'(ypos_missile), 32'd528);

    // 2: ten frames with fire held high
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t2_pre", 32'(ypos_missile), 32'(528 - 6 * (i - 1)));
      tick_edge();
      check("t2_tick", 32'(ypos_missile), 32'(528 - 6 * i));
      frame_tail();
      check("t2_hold", 32'(ypos_missile), 32'(528 - 6 * i));
    end
    check("t2_y",  32'(ypos_missile), 32'd468);
    check("t2_x",  32'(xpos_missile), 32'd398);
    check("t2_on", 32'(on_missle),    32'd1);

    // 4: hit coincident with frame tick
    hit       = 1'b1;
    vin.vblnk = 1'b1;
    step();
    hit = 1'b0;
    check("t4_on", 32'(on_missle),    32'd0);
    check("t4_y",  32'(ypos_missile), 32'd468);
    check("t4_st", 32'(dut.state_r),  32'(COOLDOWN));
    frame_tail();
    repeat (8) do_frame();
    check("t4_idle",   32'(dut.state_r), 32'(IDLE));
    check("t4_noheld", 32'(on_missle),   32'd0);
    fire = 1'b0;
    step();

    // 3: launch near the top and run to expiry
    ypos_ship = 11'd40;
    fire = 1'b1;
    step();
    check("t3_on", 32'(on_missle),    32'd1);
    check("t3_y0", 32'(ypos_missile), 32'd28);
    fire = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      do_frame();
      check("t3_y", 32'(ypos_missile), 32'(28 - 6 * i));
    end
    tick_edge();
    check("t3_end_on", 32'(on_missle),    32'd0);
    check("t3_end_y",  32'(ypos_missile), 32'd4);
    frame_tail();
    for (int i = 1; i <= 8; i++) begin
      fire_pulse();
      check("t3_cool_ign", 32'(on_missle), 32'd0);
      do_frame();
    end
    check("t3_rearm", 32'(dut.state_r), 32'(IDLE));
    fire = 1'b1;
    step();
    check("t3_relaunch", 32'(on_missle),    32'd1);
    check("t3_rel_y",    32'(ypos_missile), 32'd28);
    fire = 1'b0;
    step();

    // 6: asynchronous reset mid-flight
    vin.rgb = 12'h123;
    step();
    check("t6_pre_rgb", 32'(vout.rgb), 32'h123);
    #3;
    rst = 1'b0;
    #1;
    check("t6_on",  32'(on_missle),    32'd0);
    check("t6_x",   32'(xpos_missile), 32'd0);
    check("t6_y",   32'(ypos_missile), 32'd0);
    check("t6_rgb", 32'(vout.rgb),     32'h0);
    step();
    rst = 1'b1;
    step();
    check("t6_stay", 32'(on_missle), 32'd0);
    xpos_ship = 11'd70;
    ypos_ship = 11'd212;
    fire = 1'b1;
    step();
    check("t6_rel_on", 32'(on_missle),    32'd1);
    check("t6_rel_x",  32'(xpos_missile), 32'd100);
    check("t6_rel_y",  32'(ypos_missile), 32'd200);
    fire = 1'b0;

    // 5: pixel overlay around the missile at (100,200)
    vin.vblnk  = 1'b0;
    vin.hblnk  = 1'b0;
    vin.rgb    = 12'h0A5;
    vin.hcount = 11'd0;
    step();
    prev_h = 11'd0;
    for (int v = 199; v <= 212; v++) begin
      for (int h = 99; h <= 104; h++) begin
        vin.vcount = 11'(v);
        vin.hcount = 11'(h);
        vin.hsync  = h[0];
        vin.vsync  = v[0];
        #1;
        check("t5_lat", 32'(vout.hcount), 32'(prev_h));
        step();
        exp_rgb = (h >= 100 && h <= 103 && v >= 200 && v <= 211) ? 12'hFF0 : 12'h0A5;
        check("t5_rgb",   32'(vout.rgb),    32'(exp_rgb));
        check("t5_hcnt",  32'(vout.hcount), 32'(h));
        check("t5_vcnt",  32'(vout.vcount), 32'(v));
        check("t5_hsync", 32'(vout.hsync),  32'(h[0]));
        check("t5_vsync", 32'(vout.vsync),  32'(v[0]));
        prev_h = 11'(h);
      end
    end
    // Blanking suppresses the overlay inside the rectangle.
    vin.vcount = 11'd205;
    vin.hcount = 11'd101;
    vin.hblnk  = 1'b1;
    step();
    check("t5_blank_rgb", 32'(vout.rgb),   32'h0A5);
    check("t5_blank_out", 32'(vout.hblnk), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
